// File: rtl/fifo_frame_tx_pkg.sv
// fifo_frame_tx_pkg: shared FSM state encoding and counter widths for the FIFO-to-UART framer
package fifo_frame_tx_pkg;
    localparam int WORD_CNT_W = 13;
    localparam int STALL_W = 20;
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        SEND,
        ACK,
`ifdef FIFO_TX_CHECKSUM_EN
        CKSUM,
`endif
        DONE
    } state_t;
endpackage

// File: rtl/uart_byte_hs.sv
// uart_byte_hs: one-byte UART launch plus busy rise/fall acknowledge, with a saturating stall timer
module uart_byte_hs
    import fifo_frame_tx_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       rd_clk,
    input  logic       rst,
    input  logic       send,
    input  logic       ack,
    input  logic       fetch,
    input  logic       clr,
    input  logic [7:0] tx_byte,
    input  logic       uart_tx_busy,
    output logic       uart_tx_en,
    output logic [7:0] uart_tx_data,
    output logic       ack_done,
    output logic       timeout
);
    logic               rose;
    logic               counting;
    logic [STALL_W-1:0] stall;
    always_comb begin
        uart_tx_en   = send && !uart_tx_busy;
        uart_tx_data = uart_tx_en ? tx_byte : 8'h00;
        ack_done     = ack && rose && !uart_tx_busy;
        counting     = fetch || ack;
        timeout      = counting && stall == STALL_W'(TIMEOUT_CYC - 1);
    end
    always_ff @(posedge rd_clk or posedge rst)
        if (rst) begin
            rose  <= 1'b0;
            stall <= '0;
        end else begin
            rose  <= uart_tx_en ? 1'b0 : rose || (ack && uart_tx_busy);
            stall <= (clr || uart_tx_en) ? '0 :
                     (counting && stall != STALL_W'(TIMEOUT_CYC)) ? stall + 1'b1 : stall;
        end
endmodule

// File: rtl/fifo_frame_tx.sv
// fifo_frame_tx: frames FIFO words into MSB-first UART bytes with stall timeout (FIFO_TX_CHECKSUM_EN appends a mod-256 checksum byte)
module fifo_frame_tx
    import fifo_frame_tx_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int FRAME_LEN   = 256,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  fifo_empty,
    input  logic [DATA_W-1:0]     fifo_rd_data,
    output logic                  fifo_rd_en,
    input  logic                  uart_tx_busy,
    output logic                  uart_tx_en,
    output logic [7:0]            uart_tx_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic [WORD_CNT_W-1:0] word_count,
    output logic                  err_timeout
);
    localparam int BYTES = DATA_W / 8;
    state_t            state;
    logic [DATA_W-1:0] shift;
    logic [1:0]        byte_idx;
    logic              ack_done;
    logic              timeout;
    logic              last_word;
    logic              to_fetch;
    logic              ck_last;
`ifdef FIFO_TX_CHECKSUM_EN
    logic [7:0]        cksum;
`else
    assign ck_last = 1'b0;
`endif
    always_comb begin
        fifo_rd_en = state == FETCH && !fifo_empty;
        busy       = state != IDLE;
        frame_done = state == DONE;
        last_word  = word_count == WORD_CNT_W'(FRAME_LEN);
        to_fetch   = (state == IDLE && start) || (ack_done && byte_idx == 2'd0 && !ck_last && !last_word);
    end
    uart_byte_hs #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_hs (
        .rd_clk       (rd_clk),
        .rst          (rst),
        .send         (state == SEND),
        .ack          (state == ACK),
        .fetch        (state == FETCH),
        .clr          (to_fetch),
        .tx_byte      (shift[DATA_W-1 -: 8]),
        .uart_tx_busy (uart_tx_busy),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .ack_done     (ack_done),
        .timeout      (timeout)
    );
    always_ff @(posedge rd_clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            shift       <= '0;
            byte_idx    <= '0;
            word_count  <= '0;
            err_timeout <= 1'b0;
`ifdef FIFO_TX_CHECKSUM_EN
            cksum       <= '0;
            ck_last     <= 1'b0;
`endif
        end else
            case (state)
                IDLE:
                    if (start) begin
                        word_count  <= '0;
                        err_timeout <= 1'b0;
`ifdef FIFO_TX_CHECKSUM_EN
                        cksum       <= '0;
                        ck_last     <= 1'b0;
`endif
                        state       <= FETCH;
                    end
                FETCH:
                    if (!fifo_empty) begin
                        word_count <= word_count + 1'b1;
                        state      <= CAPTURE;
                    end else if (timeout) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end
                CAPTURE: begin
                    shift    <= fifo_rd_data;
                    byte_idx <= 2'(BYTES - 1);
                    state    <= SEND;
                end
                SEND:
                    if (uart_tx_en) begin
                        shift <= shift << 8;
`ifdef FIFO_TX_CHECKSUM_EN
                        if (!ck_last) cksum <= cksum + shift[DATA_W-1 -: 8];
`endif
                        state <= ACK;
                    end
                ACK:
                    if (ack_done) begin
                        if (byte_idx != 2'd0) begin
                            byte_idx <= byte_idx - 1'b1;
                            state    <= SEND;
                        end else if (ck_last) state <= DONE;
                        else if (!last_word) state <= FETCH;
`ifdef FIFO_TX_CHECKSUM_EN
                        else state <= CKSUM;
`else
                        else state <= DONE;
`endif
                    end else if (timeout) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end
`ifdef FIFO_TX_CHECKSUM_EN
                CKSUM: begin
                    shift    <= DATA_W'(cksum) << (DATA_W - 8);
                    byte_idx <= '0;
                    ck_last  <= 1'b1;
                    state    <= SEND;
                end
`endif
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
endmodule

// File: tb/tb_fifo_frame_tx.sv
// tb_fifo_frame_tx: directed frames against a byte-queue model of the FIFO-to-UART framer
module tb_fifo_frame_tx;
    localparam int FL = 4, TO = 100, UB = 3;
    localparam int CKB = `ifdef FIFO_TX_CHECKSUM_EN 1 `else 0 `endif;
    logic        rd_clk = 0, rst = 1, start = 0, fifo_empty = 1;
    logic [7:0]  fifo_rd_data = 0, uart_tx_data;
    logic        fifo_rd_en, uart_tx_busy, uart_tx_en, busy, frame_done, err_timeout;
    logic [12:0] word_count;
    logic        b_start = 0, b_empty = 1, b_rd_en, b_ubusy, b_en, b_busy, b_done, b_err;
    logic [15:0] b_rd_data = 0;
    logic [7:0]  b_data;
    logic [12:0] b_wc;
    logic [7:0]  fq[$], exp_q[$], rx[$], brx[$];
    logic [15:0] bq[$];
    logic [7:0]  ck = 0;
    int ucnt = 0, bcnt = 0, done_cnt = 0, pass_cnt = 0, total = 0;
    always #5 rd_clk = ~rd_clk;
    fifo_frame_tx #(.DATA_W(8), .FRAME_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .rd_clk(rd_clk), .rst(rst), .start(start), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .uart_tx_busy(uart_tx_busy),
        .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data), .busy(busy),
        .frame_done(frame_done), .word_count(word_count), .err_timeout(err_timeout)
    );
    fifo_frame_tx #(.DATA_W(16), .FRAME_LEN(2), .TIMEOUT_CYC(TO)) dut_b (
        .rd_clk(rd_clk), .rst(rst), .start(b_start), .fifo_empty(b_empty),
        .fifo_rd_data(b_rd_data), .fifo_rd_en(b_rd_en), .uart_tx_busy(b_ubusy),
        .uart_tx_en(b_en), .uart_tx_data(b_data), .busy(b_busy),
        .frame_done(b_done), .word_count(b_wc), .err_timeout(b_err)
    );
    assign uart_tx_busy = ucnt != 0;
    assign b_ubusy = bcnt != 0;
    always @(posedge rd_clk) begin
        if (fifo_rd_en && fq.size() != 0) fifo_rd_data <= fq.pop_front();
        fifo_empty <= fq.size() == 0;
        ucnt <= uart_tx_en ? UB : (ucnt != 0 ? ucnt - 1 : 0);
        if (b_rd_en && bq.size() != 0) b_rd_data <= bq.pop_front();
        b_empty <= bq.size() == 0;
        bcnt <= b_en ? UB : (bcnt != 0 ? bcnt - 1 : 0);
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask
    task automatic push_word(input logic [7:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
        ck += w;
    endtask
    task automatic close_frame();
`ifdef FIFO_TX_CHECKSUM_EN
        exp_q.push_back(ck);
`endif
        ck = 0;
    endtask
    task automatic pulse_start(output int lat);
        @(negedge rd_clk);
        start = 1;
        lat = 0;
        do begin
            @(negedge rd_clk);
            start = 0;
            lat++;
        end while (!uart_tx_en && lat < 20);
    endtask
    task automatic wait_done(input string nm);
        int n = 0;
        while (!frame_done && n < 400) begin
            @(negedge rd_clk);
            n++;
        end
        chk(nm, n < 400, 1);
        repeat (2) @(negedge rd_clk);
    endtask
    always @(negedge rd_clk)
        if (!rst) begin
            if (uart_tx_en) begin
                rx.push_back(uart_tx_data);
                chk("launch_while_uart_busy", uart_tx_busy, 0);
                if (exp_q.size() == 0) chk("extra_byte_queue", exp_q.size(), 1);
                else chk("tx_byte", uart_tx_data, exp_q.pop_front());
            end
            if (frame_done) begin
                done_cnt++;
                chk("done_bytes_left", exp_q.size(), 0);
                chk("done_word_count", word_count, FL);
                chk("done_err", err_timeout, 0);
            end
            if (b_en) brx.push_back(b_data);
        end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int lat, n, d0;
        logic [7:0] v1[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] v2[4] = '{8'hFF, 8'h02, 8'h00, 8'h00};
        logic [7:0] v3[4] = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
        logic [7:0] v4[4] = '{8'h66, 8'h77, 8'h88, 8'h99};
        repeat (3) @(posedge rd_clk);
        #1;
        chk("rst_fifo_rd_en", fifo_rd_en, 0);
        chk("rst_uart_tx_en", uart_tx_en, 0);
        chk("rst_uart_tx_data", uart_tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_err_timeout", err_timeout, 0);
        @(negedge rd_clk);
        rst = 0;
        foreach (v1[i]) push_word(v1[i]);
        close_frame();
        rx.delete();
        pulse_start(lat);
        chk("start_latency", lat, 3);
        chk("busy_in_frame", busy, 1);
        wait_done("frame1_done_seen");
        chk("frame1_done_count", done_cnt, 1);
        chk("frame1_rx_size", rx.size(), 4 + CKB);
        chk("frame1_rx0", rx[0], 8'h11);
        chk("frame1_rx1", rx[1], 8'h22);
        chk("frame1_rx2", rx[2], 8'h33);
        chk("frame1_rx3", rx[3], 8'h44);
`ifdef FIFO_TX_CHECKSUM_EN
        chk("frame1_cksum", rx[4], 8'hAA);
`endif
        chk("frame1_idle", busy, 0);
        chk("frame1_word_count_hold", word_count, 4);
        foreach (v2[i]) push_word(v2[i]);
        close_frame();
        rx.delete();
        pulse_start(lat);
        wait_done("frame2_done_seen");
        chk("frame2_done_count", done_cnt, 2);
        chk("frame2_rx0", rx[0], 8'hFF);
        chk("frame2_rx1", rx[1], 8'h02);
`ifdef FIFO_TX_CHECKSUM_EN
        chk("frame2_cksum", rx[4], 8'h01);
`endif
        foreach (v3[i]) push_word(v3[i]);
        close_frame();
        rx.delete();
        pulse_start(lat);
        repeat (3) begin
            repeat (2) @(negedge rd_clk);
            start = 1;
            @(negedge rd_clk);
            start = 0;
        end
        wait_done("frame3_done_seen");
        repeat (30) @(negedge rd_clk);
        chk("restart_done_count", done_cnt, 3);
        chk("restart_busy", busy, 0);
        chk("restart_rx_size", rx.size(), 4 + CKB);
        chk("restart_fifo_left", fq.size(), 0);
        chk("restart_word_count", word_count, 4);
        push_word(8'h01);
        push_word(8'h02);
        ck = 0;
        pulse_start(lat);
        n = 0;
        do begin
            @(negedge rd_clk);
            n++;
        end while (!uart_tx_en && n < 100);
        n = 0;
        do begin
            @(negedge rd_clk);
            n++;
        end while (!err_timeout && n < 300);
        chk("timeout_cycles", n, UB + 2 + TO);
        chk("timeout_word_count", word_count, 2);
        chk("timeout_busy", busy, 0);
        chk("timeout_err", err_timeout, 1);
        chk("timeout_no_done", done_cnt, 3);
        chk("timeout_bytes_left", exp_q.size(), 0);
        repeat (5) @(negedge rd_clk);
        chk("timeout_err_sticky", err_timeout, 1);
        foreach (v1[i]) push_word(v1[i]);
        pulse_start(lat);
        chk("start_clears_err", err_timeout, 0);
        @(negedge rd_clk);
        rst = 1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_uart_tx_en", uart_tx_en, 0);
        chk("midrst_uart_tx_data", uart_tx_data, 0);
        chk("midrst_word_count", word_count, 0);
        chk("midrst_frame_done", frame_done, 0);
        chk("midrst_err", err_timeout, 0);
        chk("midrst_fifo_rd_en", fifo_rd_en, 0);
        fq.delete();
        exp_q.delete();
        ck = 0;
        d0 = done_cnt;
        repeat (3) @(negedge rd_clk);
        rst = 0;
        chk("midrst_no_done", done_cnt, d0);
        foreach (v4[i]) push_word(v4[i]);
        close_frame();
        rx.delete();
        pulse_start(lat);
        chk("fresh_latency", lat, 3);
        wait_done("fresh_done_seen");
        chk("fresh_done_count", done_cnt, d0 + 1);
        chk("fresh_rx0", rx[0], 8'h66);
        chk("fresh_rx3", rx[3], 8'h99);
        chk("fresh_word_count", word_count, 4);
        bq.push_back(16'hA1B2);
        bq.push_back(16'hC3D4);
        brx.delete();
        @(negedge rd_clk);
        @(negedge rd_clk);
        b_start = 1;
        @(negedge rd_clk);
        b_start = 0;
        n = 0;
        while (!b_done && n < 300) begin
            @(negedge rd_clk);
            n++;
        end
        chk("wide_done_seen", n < 300, 1);
        chk("wide_word_count", b_wc, 2);
        repeat (2) @(negedge rd_clk);
        chk("wide_rx_size", brx.size(), 4 + CKB);
        chk("wide_rx0", brx[0], 8'hA1);
        chk("wide_rx1", brx[1], 8'hB2);
        chk("wide_rx2", brx[2], 8'hC3);
        chk("wide_rx3", brx[3], 8'hD4);
`ifdef FIFO_TX_CHECKSUM_EN
        chk("wide_cksum", brx[4], 8'hEA);
`endif
        chk("wide_err", b_err, 0);
        chk("wide_idle", b_busy, 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/fifo_frame_tx.md
FIFO_FRAME_TX -- requirements
Module: fifo_frame_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: FIFO word width in bits; legal values 8, 16, 24, 32.
REQ-002 The block SHALL have parameter FRAME_LEN, default 256: FIFO words per frame; legal range 1..4096.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 50000: maximum stall cycles before abort; legal range 1..2^20-1.
REQ-004 The block SHALL have rd_clk, input, 1: the single clock; all logic on rising edge.
REQ-005 The block SHALL have rst, input, 1: asynchronous, active-high reset.
REQ-006 The block SHALL have start, input, 1: single-cycle frame request.
REQ-007 The block SHALL have fifo_empty, input, 1: FIFO empty flag.
REQ-008 The block SHALL have fifo_rd_data, input, DATA_W: FIFO read data, valid the cycle after fifo_rd_en.
REQ-009 The block SHALL have fifo_rd_en, output, 1: FIFO read strobe.
REQ-010 The block SHALL have uart_tx_busy, input, 1: UART transmitter busy.
REQ-011 The block SHALL have uart_tx_en, output, 1: single-cycle byte launch.
REQ-012 The block SHALL have uart_tx_data, output, 8: byte presented to the UART.
REQ-013 The block SHALL have busy, output, 1: a frame is in progress.
REQ-014 The block SHALL have frame_done, output, 1: single-cycle pulse on successful frame end.
REQ-015 The block SHALL have word_count, output, 13: FIFO words consumed in the current frame.
REQ-016 The block SHALL have err_timeout, output, 1: sticky abort flag.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, CAPTURE, SEND, ACK, CKSUM and DONE.
REQ-018 IDLE: start=1 SHALL clear word_count and err_timeout and go to FETCH. start SHALL be ignored outside IDLE.
REQ-019 FETCH: fifo_rd_en SHALL equal (state==FETCH && !fifo_empty), combinationally. When it is 1, the FSM SHALL increment word_count and go to CAPTURE.
REQ-020 CAPTURE: the FSM SHALL load fifo_rd_data into a DATA_W shift register, set byte index to DATA_W/8-1, and go to SEND.
REQ-021 SEND: when uart_tx_busy=0, the FSM SHALL drive uart_tx_data from the most-significant unsent byte (MSB first), pulse uart_tx_en for 1 cycle, and go to ACK.
REQ-022 ACK: the FSM SHALL wait for uart_tx_busy to rise and then fall.
REQ-023 On leaving ACK with bytes remaining, the FSM SHALL go to SEND.
REQ-024 On leaving ACK with the word done and word_count<FRAME_LEN, the FSM SHALL go to FETCH.
REQ-025 On leaving ACK with the word done and word_count==FRAME_LEN, the FSM SHALL go to CKSUM (macro defined) or DONE (macro undefined).
REQ-026 DONE: the FSM SHALL pulse frame_done for 1 cycle and go to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 The stall counter SHALL clear on every uart_tx_en pulse and on entry to FETCH.
REQ-029 The stall counter SHALL increment while in FETCH or ACK. It SHALL saturate and never wrap.
REQ-030 When the stall counter reaches TIMEOUT_CYC, the FSM SHALL set err_timeout, go straight to IDLE, and SHALL NOT pulse frame_done. word_count SHALL hold for inspection.
REQ-031 fifo_empty=1 in FETCH SHALL only stall the FSM; it SHALL NOT be treated as an error before timeout.
REQ-032 Latency SHALL be 3 cycles from start to the first uart_tx_en, given fifo_empty=0 and UART idle.

Reset
REQ-033 While rst=1, regardless of the clock, the FSM SHALL be in IDLE.
REQ-034 While rst=1, all outputs SHALL be 0, and the shift register, byte index, stall counter and checksum SHALL be 0.
REQ-035 A reset mid-frame SHALL abandon the frame with no frame_done and no err_timeout.

Configuration
REQ-036 The macro FIFO_TX_CHECKSUM_EN SHALL control the checksum feature.
REQ-037 With FIFO_TX_CHECKSUM_EN defined, an 8-bit checksum SHALL accumulate every transmitted payload byte (sum mod 256) and clear on start.
REQ-038 With FIFO_TX_CHECKSUM_EN defined, CKSUM SHALL send the checksum through the same SEND/ACK handshake and then go to DONE, so a frame is FRAME_LEN*DATA_W/8+1 bytes.
REQ-039 With FIFO_TX_CHECKSUM_EN undefined, the accumulator and the CKSUM state SHALL be absent, so a frame is FRAME_LEN*DATA_W/8 bytes.

Structure
REQ-040 Package fifo_frame_tx_pkg SHALL hold the state enumeration and the constant WORD_CNT_W=13.
REQ-041 Sub-module uart_byte_hs SHALL implement the SEND/ACK launch and busy-rise/fall handshake together with the stall counter. The top level SHALL own frame sequencing.

Verification
REQ-042 DATA_W=8, FRAME_LEN=4, FIFO preloaded with 0x11,0x22,0x33,0x44, start -> the UART SHALL receive 11,22,33,44, then frame_done pulses once with word_count=4.
REQ-043 DATA_W=16, FRAME_LEN=2, words 0xA1B2 and 0xC3D4 -> the UART SHALL receive bytes A1,B2,C3,D4 in that order.
REQ-044 FIFO_TX_CHECKSUM_EN defined, bytes 0xFF,0x02 -> the UART SHALL receive FF,02,01.
REQ-045 TIMEOUT_CYC=100, FIFO emptied after word 2 of 4 -> err_timeout SHALL be set 100 cycles after entering FETCH, with word_count=2, busy=0 and no frame_done.
REQ-046 rst asserted while a frame is in ACK -> all outputs SHALL be 0 immediately, and a following start SHALL send a complete fresh frame.
REQ-047 start pulsed while busy=1 -> the running frame SHALL be unchanged and no second frame SHALL be sent.
